// File: rtl/hdsoc_link_pkg.sv
// Purpose: shared symbol constants and receive state encoding for the serial link.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hdsoc_link_pkg;

  localparam int               SYM_W      = 9;
  localparam logic [7:0]       COMMA_BYTE = 8'h3C;
  localparam logic             KCODE      = 1'b1;
  localparam logic [SYM_W-1:0] COMMA_SYM  = {KCODE, COMMA_BYTE};

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_DATA
  } rx_state_e;

endpackage

// File: rtl/rx_serial.sv
// Purpose: 9-bit LSB-first shift register plus mod-9 bit counter marking symbol boundaries.
// Latency: sym_o is combinational on the bit being sampled; sym_stb_o flags that bit as the 9th.
// Backpressure: none; one bit is consumed on every clock edge.
module rx_serial
  import hdsoc_link_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             serial_i,
  input  logic             aligned_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_stb_o
);

  logic [SYM_W-1:0] sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             last_bit;

  assign last_bit = (bit_cnt_q == 4'(SYM_W - 1));

  // Shift in the new bit at the MSB; an alignment pulse makes the next bit bit0 of a symbol.
  always_comb begin
    sr_d      = {serial_i, sr_q[SYM_W-1:1]};
    bit_cnt_d = bit_cnt_q + 4'd1;
    if (aligned_i || last_bit) begin
      bit_cnt_d = '0;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The symbol is presented with the bit being sampled so the caller can register its decision.
  assign sym_o     = sr_d;
  assign sym_stb_o = last_bit;

endmodule

// File: rtl/deserializer_out.sv
// Purpose: comma-aligned receive deserializer rebuilding N_BYTES-byte frames and flagging framing errors.
// Latency: valid_o/data_o and err_o register one cycle after the 9th bit of the deciding symbol.
// Backpressure: none; frames are presented as a single-cycle strobe and must be taken immediately.
module deserializer_out
  import hdsoc_link_pkg::SYM_W;
  import hdsoc_link_pkg::KCODE;
  import hdsoc_link_pkg::rx_state_e;
  import hdsoc_link_pkg::ST_HUNT;
  import hdsoc_link_pkg::ST_SYNC;
  import hdsoc_link_pkg::ST_DATA;
#(
  parameter logic [7:0] COMMA_BYTE = 8'h3C,
  parameter int         N_BYTES    = 3,
  parameter int         ERR_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 serial_i,
  output logic [8*N_BYTES-1:0] data_o,
  output logic                 valid_o,
  output logic                 lock_o,
  output logic                 err_o,
  output logic [ERR_W-1:0]     err_cnt_o
);

  localparam int               BC_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [SYM_W-1:0] COMMA_S = {KCODE, COMMA_BYTE};
  localparam logic [BC_W-1:0]  LAST_BC = BC_W'(N_BYTES - 1);

  logic [SYM_W-1:0] sym;
  logic             sym_stb;
  logic             aligned;
  logic             sym_k;
  logic             is_comma;

  rx_state_e                 state_q, state_d;
  logic [BC_W-1:0]           byte_cnt_q, byte_cnt_d;
  logic [N_BYTES-1:0][7:0]   bytes_q, bytes_d;
  logic [8*N_BYTES-1:0]      data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      lock_q, lock_d;
  logic [ERR_W-1:0]          err_cnt_q, err_cnt_d;

  rx_serial u_rx_serial (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .serial_i  (serial_i),
    .aligned_i (aligned),
    .sym_o     (sym),
    .sym_stb_o (sym_stb)
  );

  assign sym_k    = sym[SYM_W-1];
  assign is_comma = (sym == COMMA_S);
  // While hunting, every bit position is a candidate boundary.
  assign aligned  = (state_q == ST_HUNT) && is_comma;

  // Next-state: alignment, byte capture, frame completion and error detection.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bytes_d    = bytes_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (aligned) begin
          state_d    = ST_SYNC;
          byte_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        if (sym_stb) begin
          if (!sym_k) begin
            bytes_d[0] = sym[7:0];
            byte_cnt_d = BC_W'(1);
            state_d    = ST_DATA;
          end else if (!is_comma) begin
            err_d      = 1'b1;
            byte_cnt_d = '0;
            bytes_d    = '0;
            state_d    = ST_HUNT;
          end
        end
      end
      ST_DATA: begin
        if (sym_stb) begin
          if (sym_k) begin
            // Any control symbol inside a frame discards the partial frame.
            err_d      = 1'b1;
            byte_cnt_d = '0;
            bytes_d    = '0;
            state_d    = ST_HUNT;
          end else begin
            bytes_d[byte_cnt_q] = sym[7:0];
            if (byte_cnt_q == LAST_BC) begin
              data_d     = bytes_d;
              valid_d    = 1'b1;
              byte_cnt_d = '0;
              state_d    = ST_SYNC;
            end else begin
              byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
          end
        end
      end
      default: begin
        state_d    = ST_HUNT;
        byte_cnt_d = '0;
        bytes_d    = '0;
      end
    endcase

    lock_d    = (state_d != ST_HUNT);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_HUNT;
      byte_cnt_q <= '0;
      bytes_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bytes_q    <= bytes_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign lock_o    = lock_q;
  assign err_cnt_o = err_cnt_q;

endmodule
